// File: rtl/pop_timing_pkg.sv
// Shared FSM state, error codes and gate bookkeeping for the POP sequence monitor.
package pop_timing_pkg;

    localparam int unsigned ERR_W     = 3;
    localparam int unsigned NUM_GATES = 3;

    // Bit positions of the three sequenced gates in rise/level vectors
    localparam int unsigned GATE_PUMP  = 0;
    localparam int unsigned GATE_MW    = 1;
    localparam int unsigned GATE_PROBE = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUMP  = 3'd1,
        GAP1  = 3'd2,
        MW_ON = 3'd3,
        GAP2  = 3'd4,
        PROBE = 3'd5
    } pop_state_e;

    localparam logic [ERR_W-1:0] ERR_NONE    = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_ORDER   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_OVERLAP = ERR_W'(2);
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(3);
    localparam logic [ERR_W-1:0] ERR_SAMPLE  = ERR_W'(4);

    // Gate whose rise is legal in each state; a fall+rise chain reaches the next gate early.
    function automatic logic [NUM_GATES-1:0] expected_rise(input pop_state_e st);
        logic [NUM_GATES-1:0] exp_v;
        exp_v = NUM_GATES'(0);
        case (st)
            IDLE, PROBE:  exp_v[GATE_PUMP]  = 1'b1;
            PUMP, GAP1:   exp_v[GATE_MW]    = 1'b1;
            MW_ON, GAP2:  exp_v[GATE_PROBE] = 1'b1;
            default:      exp_v[GATE_PUMP]  = 1'b1;
        endcase
        return exp_v;
    endfunction

endpackage

// File: rtl/pop_edge_sync.sv
// Input synchroniser with rise/fall detection; disarmed for the first cycle after reset
// so a gate already high at release never reports a rise.
module pop_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;

    // While disarmed the whole chain preloads the current input, so no edge is seen on arming.
    always_comb begin
        armed_d = 1'b1;
        sync_d  = sync_q;
        prev_d  = prev_q;
        if (armed_q) begin
            sync_d[0] = din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
            prev_d = sync_q[SYNC_STAGES-1];
        end else begin
            sync_d = {SYNC_STAGES{din}};
            prev_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign level_c = sync_q[SYNC_STAGES-1];
    assign rise_c  = armed_q &  level_c & ~prev_q;
    assign fall_c  = armed_q & ~level_c &  prev_q;

endmodule

// File: rtl/pop_sequence_monitor.sv
// Measures pump / MW / probe gate timing of a POP sequence and flags ordering,
// overlap, timeout and stray-sample errors.
module pop_sequence_monitor
    import pop_timing_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pump,
    input  logic             probe,
    input  logic             MW,
    input  logic             sample,
    output logic [WIDTH-1:0] pump_width,
    output logic [WIDTH-1:0] mw_delay,
    output logic [WIDTH-1:0] mw_width,
    output logic [WIDTH-1:0] probe_delay,
    output logic [WIDTH-1:0] probe_width,
    output logic             meas_valid,
    output logic             seq_error,
    output logic [ERR_W-1:0] err_code,
    output logic [WIDTH-1:0] cycle_count
);

    logic pump_lvl, pump_rise, pump_fall;
    logic mw_lvl, mw_rise, mw_fall;
    logic probe_lvl, probe_rise, probe_fall;
    logic sample_lvl, sample_rise_unused, sample_fall_unused;

    pop_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pump (
        .clk(clk), .reset(reset), .din(pump),
        .level_c(pump_lvl), .rise_c(pump_rise), .fall_c(pump_fall)
    );
    pop_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mw (
        .clk(clk), .reset(reset), .din(MW),
        .level_c(mw_lvl), .rise_c(mw_rise), .fall_c(mw_fall)
    );
    pop_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_probe (
        .clk(clk), .reset(reset), .din(probe),
        .level_c(probe_lvl), .rise_c(probe_rise), .fall_c(probe_fall)
    );
    pop_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sample (
        .clk(clk), .reset(reset), .din(sample),
        .level_c(sample_lvl), .rise_c(sample_rise_unused), .fall_c(sample_fall_unused)
    );

    pop_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pump_width_s_q, pump_width_s_d;
    logic [WIDTH-1:0] mw_delay_s_q, mw_delay_s_d;
    logic [WIDTH-1:0] mw_width_s_q, mw_width_s_d;
    logic [WIDTH-1:0] probe_delay_s_q, probe_delay_s_d;
    logic [WIDTH-1:0] pump_width_q, pump_width_d;
    logic [WIDTH-1:0] mw_delay_q, mw_delay_d;
    logic [WIDTH-1:0] mw_width_q, mw_width_d;
    logic [WIDTH-1:0] probe_delay_q, probe_delay_d;
    logic [WIDTH-1:0] probe_width_q, probe_width_d;
    logic [WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic             meas_valid_q, meas_valid_d;
    logic             seq_error_q, seq_error_d;
    logic [ERR_W-1:0] err_code_q, err_code_d;

    logic [NUM_GATES-1:0] gate_rise_c;
    logic                 overlap_c;
    logic [WIDTH-1:0]     cnt_inc;
    logic [ERR_W-1:0]     err;

    always_comb begin
        gate_rise_c             = NUM_GATES'(0);
        gate_rise_c[GATE_PUMP]  = pump_rise;
        gate_rise_c[GATE_MW]    = mw_rise;
        gate_rise_c[GATE_PROBE] = probe_rise;
    end

    assign overlap_c = (pump_lvl & mw_lvl) | (pump_lvl & probe_lvl) | (mw_lvl & probe_lvl);

    // Next-state, measurement capture and error handling
    always_comb begin
        state_d         = state_q;
        cnt_inc         = cnt_q + WIDTH'(1);
        cnt_d           = cnt_inc;
        pump_width_s_d  = pump_width_s_q;
        mw_delay_s_d    = mw_delay_s_q;
        mw_width_s_d    = mw_width_s_q;
        probe_delay_s_d = probe_delay_s_q;
        pump_width_d    = pump_width_q;
        mw_delay_d      = mw_delay_q;
        mw_width_d      = mw_width_q;
        probe_delay_d   = probe_delay_q;
        probe_width_d   = probe_width_q;
        cycle_count_d   = cycle_count_q;
        meas_valid_d    = 1'b0;
        seq_error_d     = seq_error_q;
        err_code_d      = err_code_q;
        err             = ERR_NONE;

        // Lowest code wins when several conditions coincide
        if ((gate_rise_c & ~expected_rise(state_q)) != NUM_GATES'(0)) begin
            err = ERR_ORDER;
        end else if (overlap_c) begin
            err = ERR_OVERLAP;
        end else if ((state_q != IDLE) && (&cnt_q)) begin
            err = ERR_TIMEOUT;
        end else if (sample_lvl && (state_q != PROBE)) begin
            err = ERR_SAMPLE;
        end

        if (err != ERR_NONE) begin
            state_d     = IDLE;
            cnt_d       = WIDTH'(0);
            seq_error_d = 1'b1;
            if (!seq_error_q) begin
                err_code_d = err;
            end
        end else begin
            // The exit value is cnt+1 because the edge cycle itself belongs to the interval.
            case (state_q)
                IDLE: begin
                    cnt_d = WIDTH'(0);
                    if (pump_rise) begin
                        state_d = PUMP;
                    end
                end
                PUMP: begin
                    if (pump_fall) begin
                        pump_width_s_d = cnt_inc;
                        cnt_d          = WIDTH'(0);
                        if (mw_rise) begin
                            mw_delay_s_d = WIDTH'(0);
                            state_d      = MW_ON;
                        end else begin
                            state_d = GAP1;
                        end
                    end
                end
                GAP1: begin
                    if (mw_rise) begin
                        mw_delay_s_d = cnt_inc;
                        cnt_d        = WIDTH'(0);
                        state_d      = MW_ON;
                    end
                end
                MW_ON: begin
                    if (mw_fall) begin
                        mw_width_s_d = cnt_inc;
                        cnt_d        = WIDTH'(0);
                        if (probe_rise) begin
                            probe_delay_s_d = WIDTH'(0);
                            state_d         = PROBE;
                        end else begin
                            state_d = GAP2;
                        end
                    end
                end
                GAP2: begin
                    if (probe_rise) begin
                        probe_delay_s_d = cnt_inc;
                        cnt_d           = WIDTH'(0);
                        state_d         = PROBE;
                    end
                end
                PROBE: begin
                    if (probe_fall) begin
                        pump_width_d  = pump_width_s_q;
                        mw_delay_d    = mw_delay_s_q;
                        mw_width_d    = mw_width_s_q;
                        probe_delay_d = probe_delay_s_q;
                        probe_width_d = cnt_inc;
                        meas_valid_d  = 1'b1;
                        if (cycle_count_q != {WIDTH{1'b1}}) begin
                            cycle_count_d = cycle_count_q + WIDTH'(1);
                        end
                        cnt_d   = WIDTH'(0);
                        state_d = pump_rise ? PUMP : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = WIDTH'(0);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pump_width_s_q  <= '0;
            mw_delay_s_q    <= '0;
            mw_width_s_q    <= '0;
            probe_delay_s_q <= '0;
            pump_width_q    <= '0;
            mw_delay_q      <= '0;
            mw_width_q      <= '0;
            probe_delay_q   <= '0;
            probe_width_q   <= '0;
            cycle_count_q   <= '0;
            meas_valid_q    <= 1'b0;
            seq_error_q     <= 1'b0;
            err_code_q      <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pump_width_s_q  <= pump_width_s_d;
            mw_delay_s_q    <= mw_delay_s_d;
            mw_width_s_q    <= mw_width_s_d;
            probe_delay_s_q <= probe_delay_s_d;
            pump_width_q    <= pump_width_d;
            mw_delay_q      <= mw_delay_d;
            mw_width_q      <= mw_width_d;
            probe_delay_q   <= probe_delay_d;
            probe_width_q   <= probe_width_d;
            cycle_count_q   <= cycle_count_d;
            meas_valid_q    <= meas_valid_d;
            seq_error_q     <= seq_error_d;
            err_code_q      <= err_code_d;
        end
    end

    assign pump_width  = pump_width_q;
    assign mw_delay    = mw_delay_q;
    assign mw_width    = mw_width_q;
    assign probe_delay = probe_delay_q;
    assign probe_width = probe_width_q;
    assign cycle_count = cycle_count_q;
    assign meas_valid  = meas_valid_q;
    assign seq_error   = seq_error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// Directed bench for pop_sequence_monitor: nominal, chained, error, reset and arming scenarios.
module tb_pop_sequence_monitor;
    import pop_timing_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SYNC  = 2;

    logic             clk = 1'b0;
    logic             reset, pump, probe, mw, sample;
    logic [WIDTH-1:0] pump_width, mw_delay, mw_width, probe_delay, probe_width, cycle_count;
    logic             meas_valid, seq_error;
    logic [2:0]       err_code;

    int checks   = 0;
    int failures = 0;
    int mv_count = 0;

    pop_sequence_monitor #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .pump(pump), .probe(probe), .MW(mw), .sample(sample),
        .pump_width(pump_width), .mw_delay(mw_delay), .mw_width(mw_width),
        .probe_delay(probe_delay), .probe_width(probe_width), .meas_valid(meas_valid),
        .seq_error(seq_error), .err_code(err_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) mv_count++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1; pump = 1'b0; probe = 1'b0; mw = 1'b0; sample = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(4);
    endtask

    task automatic run_seq(input int ph, input int g1, input int mh, input int g2, input int prh);
        pump = 1'b1; idle(ph); pump = 1'b0;
        idle(g1); mw = 1'b1; idle(mh); mw = 1'b0;
        idle(g2); probe = 1'b1;
        for (int i = 0; i < prh; i++) begin
            sample = (i >= 10 && i <= 60);
            @(negedge clk);
        end
        probe = 1'b0; sample = 1'b0;
        idle(8);
    endtask

    task automatic test_reset();
        reset = 1'b1; pump = 1'b0; probe = 1'b0; mw = 1'b0; sample = 1'b0;
        idle(2);
        checks++; if ({pump_width, mw_delay, mw_width, probe_delay, probe_width} !== '0) begin
            failures++; $display("FAIL reset_meas got=%h exp=0", {pump_width, mw_delay, mw_width, probe_delay, probe_width}); end
        checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
        checks++; if (seq_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", seq_error); end
        checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", err_code); end
        checks++; if (cycle_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_nominal();
        int mv0;
        mv0 = mv_count;
        run_seq(100, 20, 50, 30, 80);
        checks++; if (mv_count - mv0 !== 1) begin failures++; $display("FAIL nom_strobes got=%0d exp=1", mv_count - mv0); end
        checks++; if (pump_width !== 16'd100) begin failures++; $display("FAIL nom_pump_width got=%0d exp=100", pump_width); end
        checks++; if (mw_delay !== 16'd20) begin failures++; $display("FAIL nom_mw_delay got=%0d exp=20", mw_delay); end
        checks++; if (mw_width !== 16'd50) begin failures++; $display("FAIL nom_mw_width got=%0d exp=50", mw_width); end
        checks++; if (probe_delay !== 16'd30) begin failures++; $display("FAIL nom_probe_delay got=%0d exp=30", probe_delay); end
        checks++; if (probe_width !== 16'd80) begin failures++; $display("FAIL nom_probe_width got=%0d exp=80", probe_width); end
        checks++; if (cycle_count !== 16'd1) begin failures++; $display("FAIL nom_count got=%0d exp=1", cycle_count); end
        checks++; if (seq_error !== 1'b0 || err_code !== 3'd0) begin
            failures++; $display("FAIL nom_error got=%b/%0d exp=0/0", seq_error, err_code); end
    endtask

    // Fall and next rise in the same cycle give zero gaps; strobe lands SYNC+1 cycles after the probe fall.
    task automatic test_gap_zero();
        pump = 1'b1; idle(7);
        pump = 1'b0; mw = 1'b1; idle(5);
        mw = 1'b0; probe = 1'b1; idle(9);
        probe = 1'b0;
        idle(SYNC);
        checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL gz_strobe_early got=%b exp=0", meas_valid); end
        idle(1);
        checks++; if (meas_valid !== 1'b1) begin failures++; $display("FAIL gz_strobe got=%b exp=1", meas_valid); end
        checks++; if ({pump_width, mw_delay, mw_width, probe_delay, probe_width} !== {16'd7, 16'd0, 16'd5, 16'd0, 16'd9}) begin
            failures++; $display("FAIL gz_meas got=%0d/%0d/%0d/%0d/%0d exp=7/0/5/0/9",
                                 pump_width, mw_delay, mw_width, probe_delay, probe_width); end
        checks++; if (cycle_count !== 16'd2) begin failures++; $display("FAIL gz_count got=%0d exp=2", cycle_count); end
        idle(1);
        checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL gz_strobe_len got=%b exp=0", meas_valid); end
        idle(4);
    endtask

    task automatic test_order();
        int mv0;
        mv0 = mv_count;
        pump = 1'b1; idle(100); pump = 1'b0;
        idle(10); probe = 1'b1; idle(20); probe = 1'b0;
        idle(8);
        checks++; if (err_code !== 3'd1 || seq_error !== 1'b1) begin
            failures++; $display("FAIL order_code got=%b/%0d exp=1/1", seq_error, err_code); end
        checks++; if (mv_count != mv0) begin failures++; $display("FAIL order_strobes got=%0d exp=0", mv_count - mv0); end
        checks++; if (pump_width !== 16'd7 || probe_width !== 16'd9 || cycle_count !== 16'd2) begin
            failures++; $display("FAIL order_hold got=%0d/%0d/%0d exp=7/9/2", pump_width, probe_width, cycle_count); end
    endtask

    task automatic test_sample();
        int mv0;
        apply_reset();
        mv0 = mv_count;
        pump = 1'b1; idle(30); pump = 1'b0;
        idle(5); sample = 1'b1; idle(5); sample = 1'b0;
        idle(10);
        checks++; if (err_code !== 3'd4 || seq_error !== 1'b1) begin
            failures++; $display("FAIL sample_code got=%b/%0d exp=1/4", seq_error, err_code); end
        checks++; if (mv_count != mv0 || cycle_count !== 16'd0) begin
            failures++; $display("FAIL sample_strobes got=%0d/%0d exp=0/0", mv_count - mv0, cycle_count); end
    endtask

    task automatic test_overlap();
        int mv0;
        apply_reset();
        pump = 1'b1; idle(40); mw = 1'b1; idle(10); mw = 1'b0;
        idle(50); pump = 1'b0;
        idle(10);
        checks++; if (err_code !== 3'd2 || seq_error !== 1'b1) begin
            failures++; $display("FAIL overlap_code got=%b/%0d exp=1/2", seq_error, err_code); end
        mv0 = mv_count;
        run_seq(100, 20, 50, 30, 80);
        checks++; if (mv_count - mv0 !== 1 || cycle_count !== 16'd1) begin
            failures++; $display("FAIL overlap_recover got=%0d/%0d exp=1/1", mv_count - mv0, cycle_count); end
        checks++; if ({pump_width, mw_delay, mw_width, probe_delay, probe_width} !== {16'd100, 16'd20, 16'd50, 16'd30, 16'd80}) begin
            failures++; $display("FAIL overlap_meas got=%0d/%0d/%0d/%0d/%0d exp=100/20/50/30/80",
                                 pump_width, mw_delay, mw_width, probe_delay, probe_width); end
        checks++; if (err_code !== 3'd2) begin failures++; $display("FAIL overlap_sticky got=%0d exp=2", err_code); end
    endtask

    task automatic test_reset_mid();
        int mv0;
        mv0 = mv_count;
        pump = 1'b1; idle(100); pump = 1'b0;
        idle(20); mw = 1'b1; idle(12);
        reset = 1'b1; mw = 1'b0;
        idle(1);
        checks++; if ({pump_width, mw_delay, mw_width, probe_delay, probe_width} !== '0) begin
            failures++; $display("FAIL rstmid_meas got=%h exp=0", {pump_width, mw_delay, mw_width, probe_delay, probe_width}); end
        checks++; if (cycle_count !== 16'd0 || seq_error !== 1'b0 || err_code !== 3'd0 || meas_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_status got=%0d/%b/%0d/%b exp=0/0/0/0", cycle_count, seq_error, err_code, meas_valid); end
        idle(1);
        reset = 1'b0;
        idle(4);
        run_seq(100, 20, 50, 30, 80);
        checks++; if (mv_count - mv0 !== 1) begin failures++; $display("FAIL rstmid_strobes got=%0d exp=1", mv_count - mv0); end
        checks++; if ({pump_width, mw_delay, mw_width, probe_delay, probe_width} !== {16'd100, 16'd20, 16'd50, 16'd30, 16'd80}) begin
            failures++; $display("FAIL rstmid_meas2 got=%0d/%0d/%0d/%0d/%0d exp=100/20/50/30/80",
                                 pump_width, mw_delay, mw_width, probe_delay, probe_width); end
        checks++; if (cycle_count !== 16'd1 || seq_error !== 1'b0) begin
            failures++; $display("FAIL rstmid_count got=%0d/%b exp=1/0", cycle_count, seq_error); end
    endtask

    // A pump held high through reset release must not start a sequence.
    task automatic test_arming();
        int mv0;
        reset = 1'b1; pump = 1'b1; probe = 1'b0; mw = 1'b0; sample = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(30); pump = 1'b0;
        idle(20);
        mv0 = mv_count;
        run_seq(100, 20, 50, 30, 80);
        checks++; if (mv_count - mv0 !== 1 || pump_width !== 16'd100 || cycle_count !== 16'd1) begin
            failures++; $display("FAIL arm_seq got=%0d/%0d/%0d exp=1/100/1", mv_count - mv0, pump_width, cycle_count); end
        checks++; if (seq_error !== 1'b0 || err_code !== 3'd0) begin
            failures++; $display("FAIL arm_error got=%b/%0d exp=0/0", seq_error, err_code); end
    endtask

    task automatic test_timeout();
        int mv0;
        apply_reset();
        mv0 = mv_count;
        pump = 1'b1; idle(10); pump = 1'b0;
        idle(65538);
        checks++; if (seq_error !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", seq_error); end
        idle(1);
        checks++; if (seq_error !== 1'b1 || err_code !== 3'd3) begin
            failures++; $display("FAIL timeout_code got=%b/%0d exp=1/3", seq_error, err_code); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL timeout_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++; if (mv_count != mv0) begin failures++; $display("FAIL timeout_strobes got=%0d exp=0", mv_count - mv0); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gap_zero();
        test_order();
        test_sample();
        test_overlap();
        test_reset_mid();
        test_arming();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
